// File: rtl/oflow_buffer_reader.sv
// Read-side controller of the previous-frame feature buffer: fetches one line
// (two objects) at a time and presents it to the PE until the PE asks for the next.
//   state     | meaning
//   IDLE      | waiting for start_read
//   FETCH     | read strobe issued for {bank, row}
//   WAIT_DATA | memory data returning, captured into the PE registers
//   PRESENT   | line held on the PE interface until a new-line request
module oflow_buffer_reader #(
    parameter int DATA_W  = 128,
    parameter int ROW_LEN = 5
) (
    input  logic                  clk,
    input  logic                  reset_N,
    input  logic                  start_read,
    input  logic                  abort,
    input  logic                  frame_num,
    input  logic [ROW_LEN+1:0]    num_of_objects,
    output logic                  read_complete,
    output logic                  mem_rd_en,
    output logic [ROW_LEN:0]      mem_rd_addr,
    input  logic [2*DATA_W-1:0]   mem_rd_data,
    output logic [DATA_W-1:0]     data_to_pe_0,
    output logic [DATA_W-1:0]     data_to_pe_1,
    output logic                  entry1_valid,
    output logic                  line_valid,
    output logic [ROW_LEN-1:0]    row_sel_to_pe,
    output logic                  done_read_to_pe,
    input  logic                  control_for_read_new_line
);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT_DATA, PRESENT} state_t;

    localparam int CNT_W = ROW_LEN + 3;
    localparam logic [CNT_W-1:0] MAX_LINES = CNT_W'(1) << ROW_LEN;

    state_t               state_q, state_d;
    logic [ROW_LEN-1:0]   row_q, row_d;
    logic                 bank_q, bank_d;
    logic [ROW_LEN-1:0]   last_row_q, last_row_d;
    logic                 odd_last_q, odd_last_d;
    logic                 rd_en_q, rd_en_d;
    logic [ROW_LEN:0]     rd_addr_q, rd_addr_d;
    logic [DATA_W-1:0]    d0_q, d0_d, d1_q, d1_d;
    logic                 e1v_q, e1v_d;
    logic                 lv_q, lv_d;
    logic [ROW_LEN-1:0]   row_sel_q, row_sel_d;
    logic                 done_q, done_d;
    logic                 rc_q, rc_d;

    // Extra width so ceil(n/2) of the largest count never wraps before clamping
    logic [CNT_W-1:0]     lines_raw;
    logic                 clamp;
    logic [ROW_LEN-1:0]   last_row_start;
    logic                 is_last;

    assign lines_raw      = (CNT_W'(num_of_objects) + CNT_W'(1)) >> 1;
    assign clamp          = lines_raw > MAX_LINES;
    assign last_row_start = clamp ? '1 : ROW_LEN'(lines_raw - CNT_W'(1));
    assign is_last        = (row_q == last_row_q);

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        bank_d     = bank_q;
        last_row_d = last_row_q;
        odd_last_d = odd_last_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        d0_d       = d0_q;
        d1_d       = d1_q;
        e1v_d      = e1v_q;
        lv_d       = lv_q;
        row_sel_d  = row_sel_q;
        done_d     = done_q;
        rc_d       = 1'b0;
        if (abort) begin
            state_d = IDLE;
            lv_d    = 1'b0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_read) begin
                        if (lines_raw == '0) begin
                            rc_d = 1'b1;
                        end else begin
                            bank_d     = frame_num;
                            last_row_d = last_row_start;
                            // A clamped count always fills the last line
                            odd_last_d = num_of_objects[0] && !clamp;
                            row_d      = '0;
                            rd_en_d    = 1'b1;
                            rd_addr_d  = {frame_num, {ROW_LEN{1'b0}}};
                            state_d    = FETCH;
                        end
                    end
                end
                FETCH: state_d = WAIT_DATA;
                WAIT_DATA: begin
                    e1v_d     = !(is_last && odd_last_q);
                    d0_d      = mem_rd_data[DATA_W-1:0];
                    d1_d      = e1v_d ? mem_rd_data[2*DATA_W-1:DATA_W] : '0;
                    row_sel_d = row_q;
                    lv_d      = 1'b1;
                    done_d    = is_last;
                    state_d   = PRESENT;
                end
                PRESENT: begin
                    if (control_for_read_new_line) begin
                        lv_d   = 1'b0;
                        done_d = 1'b0;
                        if (is_last) begin
                            rc_d    = 1'b1;
                            state_d = IDLE;
                        end else begin
                            row_d     = row_q + 1'b1;
                            rd_en_d   = 1'b1;
                            rd_addr_d = {bank_q, row_q + 1'b1};
                            state_d   = FETCH;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state_q    <= IDLE;
            row_q      <= '0;
            bank_q     <= 1'b0;
            last_row_q <= '0;
            odd_last_q <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            d0_q       <= '0;
            d1_q       <= '0;
            e1v_q      <= 1'b0;
            lv_q       <= 1'b0;
            row_sel_q  <= '0;
            done_q     <= 1'b0;
            rc_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            bank_q     <= bank_d;
            last_row_q <= last_row_d;
            odd_last_q <= odd_last_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            d0_q       <= d0_d;
            d1_q       <= d1_d;
            e1v_q      <= e1v_d;
            lv_q       <= lv_d;
            row_sel_q  <= row_sel_d;
            done_q     <= done_d;
            rc_q       <= rc_d;
        end
    end

    assign read_complete   = rc_q;
    assign mem_rd_en       = rd_en_q;
    assign mem_rd_addr     = rd_addr_q;
    assign data_to_pe_0    = d0_q;
    assign data_to_pe_1    = d1_q;
    assign entry1_valid    = e1v_q;
    assign line_valid      = lv_q;
    assign row_sel_to_pe   = row_sel_q;
    assign done_read_to_pe = done_q;

endmodule

// File: tb/tb_oflow_buffer_reader.sv
// Scoreboard bench for oflow_buffer_reader: stimulus pushes expected reads, lines and
// completions; a negedge monitor pops and compares whenever the DUT presents them.
module tb_oflow_buffer_reader;

    localparam int DATA_W  = 128;
    localparam int ROW_LEN = 5;

    logic                  clk;
    logic                  reset_N;
    logic                  start_read, abort, frame_num;
    logic [ROW_LEN+1:0]    num_of_objects;
    logic                  read_complete, mem_rd_en;
    logic [ROW_LEN:0]      mem_rd_addr;
    logic [2*DATA_W-1:0]   mem_rd_data;
    logic [DATA_W-1:0]     data_to_pe_0, data_to_pe_1;
    logic                  entry1_valid, line_valid, done_read_to_pe;
    logic [ROW_LEN-1:0]    row_sel_to_pe;
    logic                  control_for_read_new_line;

    oflow_buffer_reader #(.DATA_W(DATA_W), .ROW_LEN(ROW_LEN)) dut (
        .clk(clk), .reset_N(reset_N), .start_read(start_read), .abort(abort),
        .frame_num(frame_num), .num_of_objects(num_of_objects),
        .read_complete(read_complete), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .data_to_pe_0(data_to_pe_0), .data_to_pe_1(data_to_pe_1),
        .entry1_valid(entry1_valid), .line_valid(line_valid), .row_sel_to_pe(row_sel_to_pe),
        .done_read_to_pe(done_read_to_pe),
        .control_for_read_new_line(control_for_read_new_line)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]   row;
        logic [127:0] d0;
        logic [127:0] d1;
        logic         e1v;
        logic         done;
    } line_t;

    line_t      exp_lines[$];
    logic [5:0] exp_addr[$];
    int         rc_pending = 0;
    int         checks = 0;
    int         failures = 0;

    function automatic logic [127:0] ent(logic [5:0] a, logic e);
        return {16'hBEEF, 2'b00, a, 7'd0, e, 96'h0123_4567_89AB_CDEF_0011_2233};
    endfunction

    // Memory model: one-cycle latency, garbage when not reading
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= {ent(mem_rd_addr, 1'b1), ent(mem_rd_addr, 1'b0)};
        else           mem_rd_data <= {8{32'hDEAD_F00D}};
    end

    task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_cond(string name, logic ok, logic [255:0] act);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL %s: condition false, observed %0h", name, act);
        end
    endtask

    // Expected read address and presented line for row r of a stream
    task automatic push_exp(int n, logic fn, int r);
        int    raw, lines;
        logic  clamped;
        line_t e;
        logic [5:0] a;
        raw     = (n + 1) / 2;
        clamped = raw > 32;
        lines   = clamped ? 32 : raw;
        a       = {fn, 5'(r)};
        e.row   = 5'(r);
        e.done  = (r == lines - 1);
        e.e1v   = !(e.done && (n % 2 == 1) && !clamped);
        e.d0    = ent(a, 1'b0);
        e.d1    = e.e1v ? ent(a, 1'b1) : 128'h0;
        exp_addr.push_back(a);
        exp_lines.push_back(e);
    endtask

    logic       lv_prev, rd_prev;
    logic [5:0] mon_a;
    line_t      mon_e;

    always @(negedge clk) begin
        if (!reset_N) begin
            lv_prev = 1'b0;
            rd_prev = 1'b0;
        end else begin
            if (mem_rd_en) begin
                chk("rd_en_back_to_back", rd_prev, 1'b0);
                chk_cond("read_expected", exp_addr.size() != 0, mem_rd_addr);
                if (exp_addr.size() != 0) begin
                    mon_a = exp_addr.pop_front();
                    chk("rd_addr", mem_rd_addr, mon_a);
                end
            end
            if (line_valid && !lv_prev) begin
                chk_cond("line_expected", exp_lines.size() != 0, row_sel_to_pe);
                if (exp_lines.size() != 0) begin
                    mon_e = exp_lines.pop_front();
                    chk("row_sel", row_sel_to_pe, mon_e.row);
                    chk("data0", data_to_pe_0, mon_e.d0);
                    chk("data1", data_to_pe_1, mon_e.d1);
                    chk("entry1_valid", entry1_valid, mon_e.e1v);
                    chk("done_read", done_read_to_pe, mon_e.done);
                end
            end
            if (read_complete) begin
                chk_cond("read_complete_expected", rc_pending != 0, rc_pending);
                if (rc_pending != 0) rc_pending--;
                chk("read_complete_lv", line_valid, 1'b0);
            end
            lv_prev = line_valid;
            rd_prev = mem_rd_en;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(int n, logic fn);
        num_of_objects = 7'(n);
        frame_num      = fn;
        start_read     = 1'b1;
        tick();
        start_read     = 1'b0;
    endtask

    task automatic wait_lv();
        int i;
        for (i = 0; i < 20 && !line_valid; i++) tick();
        chk_cond("line_valid_timeout", line_valid, i);
    endtask

    task automatic serve(int dly);
        wait_lv();
        repeat (dly) tick();
        control_for_read_new_line = 1'b1;
        tick();
        control_for_read_new_line = 1'b0;
    endtask

    task automatic drain_check(string name);
        chk({name, "_addr_q"}, exp_addr.size(), 0);
        chk({name, "_line_q"}, exp_lines.size(), 0);
        chk({name, "_rc"}, rc_pending, 0);
    endtask

    task automatic chk_outputs_zero(string name);
        chk({name, "_ctl"}, {read_complete, mem_rd_en, mem_rd_addr, entry1_valid,
                             line_valid, row_sel_to_pe, done_read_to_pe}, 0);
        chk({name, "_data"}, {data_to_pe_0, data_to_pe_1}, 0);
    endtask

    logic [255:0] snap_d;
    logic [7:0]   snap_c;
    logic         stable, lv_seen;

    initial begin
        reset_N = 1'b0;
        start_read = 1'b0; abort = 1'b0; frame_num = 1'b0;
        num_of_objects = '0; control_for_read_new_line = 1'b0;
        repeat (3) tick();
        chk_outputs_zero("reset");
        reset_N = 1'b1;
        tick();

        // 5 objects from bank 1, PE requests one cycle after each line appears
        for (int r = 0; r < 3; r++) push_exp(5, 1'b1, r);
        rc_pending++;
        start(5, 1'b1);
        chk("s1_rd_en_c1", mem_rd_en, 1'b1);
        tick();
        chk("s1_lv_c2", {line_valid, mem_rd_en}, 2'b00);
        tick();
        chk("s1_lv_c3", line_valid, 1'b1);
        repeat (3) serve(1);
        chk("s1_rc_after_last", read_complete, 1'b1);
        tick();
        chk("s1_rc_one_pulse", read_complete, 1'b0);
        drain_check("s1");

        // Zero objects: completion only
        rc_pending++;
        start(0, 1'b1);
        chk("s2_rc_c1", {read_complete, mem_rd_en}, 2'b10);
        lv_seen = 1'b0;
        repeat (5) begin tick(); lv_seen |= line_valid | mem_rd_en; end
        chk("s2_quiet", lv_seen, 1'b0);
        drain_check("s2");

        // 4 objects, PE stalls 10 cycles on row 0
        for (int r = 0; r < 2; r++) push_exp(4, 1'b0, r);
        rc_pending++;
        start(4, 1'b0);
        wait_lv();
        snap_d = {data_to_pe_0, data_to_pe_1};
        snap_c = {row_sel_to_pe, entry1_valid, line_valid, done_read_to_pe};
        stable = 1'b1;
        repeat (10) begin
            tick();
            if ({data_to_pe_0, data_to_pe_1} !== snap_d ||
                {row_sel_to_pe, entry1_valid, line_valid, done_read_to_pe} !== snap_c)
                stable = 1'b0;
        end
        chk("s3_stable", stable, 1'b1);
        control_for_read_new_line = 1'b1;
        tick();
        control_for_read_new_line = 1'b0;
        chk("s3_p1", {line_valid, mem_rd_en}, 2'b01);
        tick();
        chk("s3_p2", line_valid, 1'b0);
        tick();
        chk("s3_p3", {line_valid, row_sel_to_pe}, {1'b1, 5'd1});
        serve(1);
        tick();
        drain_check("s3");

        // Abort in WAIT_DATA of row 1 (6 lines), then restart on bank 0
        push_exp(12, 1'b1, 0);
        exp_addr.push_back(6'h21);
        start(12, 1'b1);
        serve(1);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("s4_idle", {line_valid, mem_rd_en, read_complete, done_read_to_pe}, 4'b0000);
        repeat (4) tick();
        push_exp(2, 1'b0, 0);
        rc_pending++;
        start(2, 1'b0);
        serve(1);
        tick();
        drain_check("s4");

        // start_read pulses during PRESENT are ignored
        for (int r = 0; r < 3; r++) push_exp(6, 1'b0, r);
        rc_pending++;
        start(6, 1'b0);
        repeat (3) begin
            wait_lv();
            num_of_objects = 7'd1;
            frame_num      = 1'b1;
            start_read     = 1'b1;
            tick();
            start_read     = 1'b0;
            control_for_read_new_line = 1'b1;
            tick();
            control_for_read_new_line = 1'b0;
        end
        repeat (3) tick();
        drain_check("s5");

        // 70 objects clamp to 32 lines
        for (int r = 0; r < 32; r++) push_exp(70, 1'b1, r);
        rc_pending++;
        start(70, 1'b1);
        repeat (32) serve(0);
        tick();
        drain_check("s6");

        // Reset mid-stream, then a clean restart
        for (int r = 0; r < 3; r++) push_exp(8, 1'b1, r);
        start(8, 1'b1);
        serve(1);
        serve(1);
        wait_lv();
        tick();
        reset_N = 1'b0;
        #1;
        chk_outputs_zero("s7_async_reset");
        repeat (2) tick();
        reset_N = 1'b1;
        tick();
        drain_check("s7_pre");
        for (int r = 0; r < 2; r++) push_exp(3, 1'b0, r);
        rc_pending++;
        start(3, 1'b0);
        repeat (2) serve(1);
        tick();
        drain_check("s7");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached, got %0t expected completion", $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/oflow_buffer_reader.md
# oflow_buffer_reader

Read-side controller of the previous-frame feature buffer. On a start pulse it streams stored object features, two objects per buffer line, into a processing element over the `data_to_pe_0/1`, `row_sel_to_pe` and `done_read_to_pe` interface. It advances to the next line only when the PE raises `control_for_read_new_line`. The ping-pong bank holding the previous frame is selected by `frame_num`; core_fsm gets a completion pulse when every line has been consumed.

## Interface
Parameters:
- DATA_W, 128: width of one object entry (`DATA_TO_PE_WIDTH`).
- ROW_LEN, 5: line-index width; a bank holds up to 2^ROW_LEN lines.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  clock.
  - reset_N  in  1  asynchronous active-low reset.
- Control from core_fsm:
  - start_read  in  1  one-cycle pulse; begins streaming. Sampled only in IDLE.
  - abort  in  1  synchronous return to IDLE (tied to done_pe).
  - frame_num  in  1  bank holding the previous frame; latched at start.
  - num_of_objects  in  ROW_LEN+2  object count; latched at start.
  - read_complete  out  1  one-cycle pulse when the last line is consumed.
- Memory read port:
  - mem_rd_en  out  1  read strobe.
  - mem_rd_addr  out  ROW_LEN+1  read address, {bank, row}.
  - mem_rd_data  in  2*DATA_W  read data; entry0 is in the low half. Latency is 1 cycle.
- PE side:
  - data_to_pe_0  out  DATA_W  entry 0 of the presented line.
  - data_to_pe_1  out  DATA_W  entry 1 of the presented line; zero when invalid.
  - entry1_valid  out  1  entry 1 holds a real object.
  - line_valid  out  1  data_to_pe_* and row_sel_to_pe are valid.
  - row_sel_to_pe  out  ROW_LEN  index of the presented line.
  - done_read_to_pe  out  1  the presented line is the last line (level).
  - control_for_read_new_line  in  1  PE request for the next line.

## Operation
- Line count: lines = ceil(num_of_objects/2), clamped to 2^ROW_LEN. The last line has an invalid entry 1 when num_of_objects is odd.
- State machine: IDLE, FETCH, WAIT_DATA, PRESENT.
- IDLE:
  - start_read with lines > 0: latch bank and count, row := 0, go to FETCH.
  - start_read with lines = 0: pulse read_complete for 1 cycle, do no memory access, stay in IDLE.
- FETCH: mem_rd_en = 1, mem_rd_addr = {bank, row}; go to WAIT_DATA.
- WAIT_DATA: register mem_rd_data into data_to_pe_0/1. Zero data_to_pe_1 when entry 1 is invalid. Set row_sel_to_pe := row and line_valid := 1; go to PRESENT.
- PRESENT:
  - Outputs hold. done_read_to_pe = 1 iff row == lines-1.
  - On control_for_read_new_line, not the last line: row := row+1, line_valid := 0, go to FETCH.
  - On control_for_read_new_line, last line: read_complete pulse, clear line_valid, go to IDLE.
- control_for_read_new_line is ignored outside PRESENT.
- start_read is ignored outside IDLE.
- abort in any state: go to IDLE next cycle with line_valid, done_read_to_pe and mem_rd_en cleared. No read_complete. abort beats start_read in the same cycle.
- Reset: all outputs 0, state IDLE, row 0. A reset mid-stream discards everything.
- Leaving PRESENT: data_to_pe_* keep their last values; only line_valid qualifies them.

## Timing
- All outputs are registered.
- start_read sampled at the edge ending cycle C:
  - mem_rd_en high in C+1.
  - Data returned in C+2.
  - line_valid, data_to_pe_* and row_sel_to_pe valid from C+3.
- Request sampled in PRESENT in cycle P:
  - line_valid low in P+1 and P+2.
  - mem_rd_en high in P+1.
  - Next line presented in P+3.
- This 2-cycle gap matches the PE raising its request 2 cycles before it finishes a line.
- mem_rd_en is never high for more than 1 consecutive cycle. There is at most one read outstanding.
- read_complete is high in the cycle after the final request is sampled.
- done_read_to_pe changes only with line_valid updates.

## Test plan
- num_of_objects=5, frame_num=1, PE requests 1 cycle after each line_valid rises:
  - Addresses 0x20, 0x21, 0x22 issued.
  - Rows 0, 1, 2 presented.
  - entry1_valid=0 and data_to_pe_1=0 on row 2.
  - done_read_to_pe only on row 2.
  - read_complete one pulse after the third request.
- num_of_objects=0: read_complete pulses in C+1; mem_rd_en never high; line_valid stays 0.
- num_of_objects=4, PE delays its request 10 cycles on row 0: outputs are stable for all 10 cycles; row 1 appears exactly 3 cycles after the request.
- abort while in WAIT_DATA on row 1 of 6 lines: IDLE next cycle, no read_complete. A new start with frame_num=0 then reads from address 0x00.
- start_read pulses during PRESENT: ignored; the row sequence is unchanged.
- num_of_objects=70, ROW_LEN=5: clamped to 32 lines; last row 31 has done_read_to_pe=1 and entry1_valid=1.
- Reset asserted mid-stream: all outputs 0 immediately; the next start restarts from row 0.
